// File: rtl/pattern_pkg.sv
// Shared encodings for the stream pattern generator/checker.
package pattern_pkg;

    typedef enum logic {
        MODE_COUNT = 1'b0,
        MODE_LFSR  = 1'b1
    } mode_e;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } chk_state_e;

    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

endpackage

// File: rtl/pattern_step.sv
// Combinational next-word function: replicated lane counter or Galois LFSR.
module pattern_step
    import pattern_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    LANE_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(DEFAULT_TAPS)
) (
    input  mode_e                 mode,
    input  logic [DATA_WIDTH-1:0] cur,
    output logic [DATA_WIDTH-1:0] nxt
);

    localparam int LANES = DATA_WIDTH / LANE_WIDTH;

    // Counter mode derives every lane from lane 0, so a received word seeds cleanly.
    logic [LANE_WIDTH-1:0] lane_nxt;
    assign lane_nxt = cur[LANE_WIDTH-1:0] + LANE_WIDTH'(1);

    always_comb begin
        nxt = {LANES{lane_nxt}};
        if (mode == MODE_LFSR)
            nxt = {1'b0, cur[DATA_WIDTH-1:1]} ^ (cur[0] ? LFSR_TAPS : '0);
    end

endmodule

// File: rtl/stream_pattern_tester.sv
// Pattern generator feeding the bridge TX FIFO and lock/compare checker draining RX.
module stream_pattern_tester
    import pattern_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 16,
    parameter int                    LANE_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS     = DATA_WIDTH'(DEFAULT_TAPS),
    parameter logic [DATA_WIDTH-1:0] LFSR_SEED     = DATA_WIDTH'(1),
    parameter int                    COUNT_WIDTH   = 24,
    parameter int                    RESYNC_THRESH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   clear,
    input  logic                   mode,
    output logic                   tx_en,
    output logic [DATA_WIDTH-1:0]  tx_data,
    input  logic                   tx_full,
    output logic                   rx_en,
    input  logic [DATA_WIDTH-1:0]  rx_data,
    input  logic                   rx_empty,
    output logic                   locked,
    output logic [COUNT_WIDTH-1:0] word_count,
    output logic [COUNT_WIDTH-1:0] err_count,
    output logic [7:0]             resync_count,
    output logic                   first_err_valid,
    output logic [DATA_WIDTH-1:0]  first_err_exp,
    output logic [DATA_WIDTH-1:0]  first_err_got,
    output logic [7:0]             status
);

    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int CW    = $clog2(RESYNC_THRESH + 1);
    localparam int NW    = $clog2(LANES + 1);

    logic                  run_q;
    mode_e                 mode_q, mode_nxt;
    logic                  mode_chg;
    logic [DATA_WIDTH-1:0] seed, gen_q, gen_nxt;
    logic [DATA_WIDTH-1:0] expect_q, expect_nxt, chk_in;
    chk_state_e            state_q, state_d;
    logic [CW-1:0]         consec_q;
    logic [NW-1:0]         nerr;
    logic                  word_err, resync;
    logic [COUNT_WIDTH:0]  err_sum;

    // mode only follows the pin while stopped; a change reseeds both halves.
    assign mode_nxt = run_q ? mode_q : mode_e'(mode);
    assign mode_chg = ~run_q & (mode_nxt != mode_q);
    assign seed     = (mode_nxt == MODE_LFSR) ? LFSR_SEED : '0;

    assign tx_en   = run_q & ~tx_full;
    assign rx_en   = run_q & ~rx_empty;
    assign tx_data = gen_q;
    assign locked  = (state_q == ST_LOCKED);
    assign status  = word_count[8:1];

    pattern_step #(.DATA_WIDTH(DATA_WIDTH), .LANE_WIDTH(LANE_WIDTH), .LFSR_TAPS(LFSR_TAPS))
        u_gen_step (.mode(mode_q), .cur(gen_q), .nxt(gen_nxt));

    // HUNT seeds from the received word; LOCKED free-runs on its own expectation.
    assign chk_in = (state_q == ST_HUNT) ? rx_data : expect_q;

    pattern_step #(.DATA_WIDTH(DATA_WIDTH), .LANE_WIDTH(LANE_WIDTH), .LFSR_TAPS(LFSR_TAPS))
        u_chk_step (.mode(mode_q), .cur(chk_in), .nxt(expect_nxt));

    always_comb begin
        nerr = '0;
        for (int l = 0; l < LANES; l++)
            if (rx_data[l*LANE_WIDTH +: LANE_WIDTH] != expect_q[l*LANE_WIDTH +: LANE_WIDTH])
                nerr = nerr + NW'(1);
    end

    assign word_err = (nerr != '0);
    assign resync   = rx_en & ~clear & locked & word_err & (consec_q == CW'(RESYNC_THRESH - 1));
    assign err_sum  = {1'b0, err_count} + (COUNT_WIDTH + 1)'(nerr);

    always_comb begin
        state_d = state_q;
        if (clear || mode_chg)
            state_d = ST_HUNT;
        else if (rx_en) begin
            case (state_q)
                ST_HUNT:   state_d = ST_LOCKED;
                ST_LOCKED: if (resync) state_d = ST_HUNT;
                default:   state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_HUNT;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q           <= 1'b0;
            mode_q          <= MODE_COUNT;
            gen_q           <= '0;
            expect_q        <= '0;
            consec_q        <= '0;
            word_count      <= '0;
            err_count       <= '0;
            resync_count    <= '0;
            first_err_valid <= 1'b0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
        end else begin
            run_q <= run;
            if (!run_q) mode_q <= mode_e'(mode);

            if (clear || mode_chg) gen_q <= seed;
            else if (tx_en)        gen_q <= gen_nxt;

            if (clear) begin
                expect_q        <= '0;
                consec_q        <= '0;
                word_count      <= '0;
                err_count       <= '0;
                resync_count    <= '0;
                first_err_valid <= 1'b0;
                first_err_exp   <= '0;
                first_err_got   <= '0;
            end else if (mode_chg) begin
                consec_q <= '0;
            end else if (rx_en) begin
                expect_q <= expect_nxt;
                if (locked) begin
                    if (word_count != '1) word_count <= word_count + COUNT_WIDTH'(1);
                    err_count <= err_sum[COUNT_WIDTH] ? '1 : err_sum[COUNT_WIDTH-1:0];
                    if (word_err) begin
                        consec_q <= resync ? '0 : consec_q + CW'(1);
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_exp   <= expect_q;
                            first_err_got   <= rx_data;
                        end
                    end else begin
                        consec_q <= '0;
                    end
                    if (resync && resync_count != '1) resync_count <= resync_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_pattern_tester.sv
// Directed bench: TX words scoreboarded through a queue, RX checker driven via a model FIFO.
module tb_stream_pattern_tester;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0, clear = 1'b0, mode = 1'b0;
    logic        tx_en, tx_full = 1'b1;
    logic [15:0] tx_data;
    logic        rx_en, rx_empty = 1'b1;
    logic [15:0] rx_data = '0;
    logic        locked, first_err_valid;
    logic [23:0] word_count, err_count;
    logic [7:0]  resync_count, status;
    logic [15:0] first_err_exp, first_err_got;

    stream_pattern_tester dut (
        .clk(clk), .rst_n(rst_n), .run(run), .clear(clear), .mode(mode),
        .tx_en(tx_en), .tx_data(tx_data), .tx_full(tx_full),
        .rx_en(rx_en), .rx_data(rx_data), .rx_empty(rx_empty),
        .locked(locked), .word_count(word_count), .err_count(err_count),
        .resync_count(resync_count), .first_err_valid(first_err_valid),
        .first_err_exp(first_err_exp), .first_err_got(first_err_got),
        .status(status)
    );

    always #5 clk = ~clk;

    int n_total = 0, n_pass = 0;
    logic [15:0] exp_q[$];
    logic [15:0] fifo[$];
    logic        mon_en = 1'b0;
    int          rd_cnt = 0, tx_cnt = 0, viol = 0, rd_limit = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) $display("FAIL %s got=%h expected=%h", nm, got, want);
        else n_pass++;
    endtask

    // Monitor: every TX strobe while enabled pops one expected word.
    always @(negedge clk) begin
        #2;
        if (mon_en && tx_en) begin
            if (exp_q.size() == 0) chk("tx_unexpected", {16'h0, tx_data}, 32'hFFFF_FFFF);
            else                   chk("tx_data", {16'h0, tx_data}, {16'h0, exp_q.pop_front()});
        end
    end

    // One bus cycle through the 16-deep model FIFO; strobes sampled ahead of the edge they act on.
    task automatic lb(input int stall_pct, input bit mon, input bit rx_on);
        @(negedge clk);
        mon_en   = mon;
        tx_full  = (fifo.size() >= 16) || ($urandom_range(99) < stall_pct);
        rx_empty = !rx_on || (fifo.size() == 0) || (rd_cnt >= rd_limit) ||
                   ($urandom_range(99) < stall_pct);
        rx_data  = (fifo.size() != 0) ? fifo[0] : 16'h0;
        #1;
        if (tx_en && tx_full)  viol++;
        if (rx_en && rx_empty) viol++;
        if (tx_en) tx_cnt++;
        if (rx_en) begin void'(fifo.pop_front()); rd_cnt++; end
        if (tx_en && rx_on) fifo.push_back(tx_data);
    endtask

    task automatic idle();
        @(negedge clk);
        mon_en = 1'b0; tx_full = 1'b1; rx_empty = 1'b1;
    endtask

    task automatic feed(input logic [15:0] w);
        @(negedge clk);
        rx_data = w; rx_empty = 1'b0;
        @(negedge clk);
        rx_empty = 1'b1;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    initial begin
        int cyc;
        bit seen;
        int prev;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_en", {31'h0, tx_en}, 0);
        chk("rst_rx_en", {31'h0, rx_en}, 0);
        chk("rst_locked", {31'h0, locked}, 0);
        chk("rst_word_count", {8'h0, word_count}, 0);
        chk("rst_err_count", {8'h0, err_count}, 0);
        chk("rst_first_err_valid", {31'h0, first_err_valid}, 0);
        rst_n = 1'b1;

        // Counter generator, no backpressure, 258 words with a wrap
        run = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 258; i++) begin
            logic [7:0] b;
            b = 8'(i);
            exp_q.push_back({b, b});
        end
        tx_cnt = 0;
        for (int i = 0; i < 258; i++) lb(0, 1'b1, 1'b0);
        idle();
        chk("cnt_tx_every_cycle", tx_cnt, 258);
        chk("cnt_sb_drained", exp_q.size(), 0);

        // LFSR mode loopback
        run = 1'b0;
        @(negedge clk); mode = 1'b1;
        @(negedge clk); run = 1'b1;
        @(negedge clk);
        exp_q.push_back(16'h0001); exp_q.push_back(16'hB400);
        exp_q.push_back(16'h5A00); exp_q.push_back(16'h2D00);
        fifo.delete(); rd_cnt = 0; rd_limit = 1000000;
        for (int i = 0; i < 44; i++) lb(0, i < 4, 1'b1);
        idle();
        chk("lfsr_sb_drained", exp_q.size(), 0);
        chk("lfsr_err_count", {8'h0, err_count}, 0);
        chk("lfsr_locked", {31'h0, locked}, 1);
        chk("lfsr_word_count", {8'h0, word_count}, rd_cnt - 1);

        // Counter loopback with random stalls, 1000 words
        run = 1'b0;
        @(negedge clk); mode = 1'b0;
        @(negedge clk);
        pulse_clear();
        run = 1'b1;
        @(negedge clk);
        fifo.delete(); rd_cnt = 0; viol = 0; rd_limit = 1000;
        cyc = 0; seen = 0;
        while (rd_cnt < 1000 && cyc < 20000) begin
            prev = rd_cnt;
            lb(25, 1'b0, 1'b1);
            if (prev >= 1 && !seen) begin
                seen = 1;
                chk("loop_locked_after_first", {31'h0, locked}, 1);
            end
            cyc++;
        end
        idle();
        chk("loop_no_timeout", {31'h0, cyc < 20000}, 1);
        chk("loop_word_count", {8'h0, word_count}, 999);
        chk("loop_err_count", {8'h0, err_count}, 0);
        chk("loop_resync", {24'h0, resync_count}, 0);
        chk("loop_locked", {31'h0, locked}, 1);
        chk("loop_status", {24'h0, status}, 32'hF3);
        chk("loop_protocol", viol, 0);

        // Single-lane corruption
        run = 1'b0;
        @(negedge clk);
        pulse_clear();
        run = 1'b1;
        @(negedge clk);
        feed(16'h0303); feed(16'h0404); feed(16'h0512); feed(16'h0606);
        chk("inj_err_count", {8'h0, err_count}, 1);
        chk("inj_first_exp", {16'h0, first_err_exp}, 32'h0505);
        chk("inj_first_got", {16'h0, first_err_got}, 32'h0512);
        chk("inj_first_valid", {31'h0, first_err_valid}, 1);
        chk("inj_locked", {31'h0, locked}, 1);
        chk("inj_word_count", {8'h0, word_count}, 3);

        // Dropped word -> resync after four bad words, then relock
        pulse_clear();
        feed(16'h0000); feed(16'h0101); feed(16'h0202);
        feed(16'h0404); feed(16'h0505); feed(16'h0606);
        chk("drop_locked_before_thresh", {31'h0, locked}, 1);
        feed(16'h0707);
        chk("drop_err_count", {8'h0, err_count}, 8);
        chk("drop_resync", {24'h0, resync_count}, 1);
        chk("drop_hunt", {31'h0, locked}, 0);
        chk("drop_first_got", {16'h0, first_err_got}, 32'h0404);
        feed(16'h0808);
        chk("drop_relock", {31'h0, locked}, 1);
        feed(16'h0909); feed(16'h0A0A);
        chk("drop_err_stays", {8'h0, err_count}, 8);
        chk("drop_word_count", {8'h0, word_count}, 8);

        // Async reset mid-burst
        @(negedge clk);
        tx_full = 1'b0; rx_empty = 1'b0; rx_data = 16'h0B0B;
        #2;
        chk("burst_tx_en", {31'h0, tx_en}, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_tx_en", {31'h0, tx_en}, 0);
        chk("arst_rx_en", {31'h0, rx_en}, 0);
        chk("arst_word_count", {8'h0, word_count}, 0);
        chk("arst_err_count", {8'h0, err_count}, 0);
        chk("arst_resync", {24'h0, resync_count}, 0);
        @(negedge clk);
        rst_n = 1'b1; rx_empty = 1'b1; tx_full = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("gen_after_rst", {16'h0, tx_data}, 32'h0303);
        tx_full = 1'b1;
        feed(16'h0000); feed(16'h0101);
        chk("pre_clear_wc", {8'h0, word_count}, 1);

        // Clear with both strobes active: reseed, and the consumed word is ignored
        @(negedge clk);
        clear = 1'b1; tx_full = 1'b0; rx_empty = 1'b0; rx_data = 16'h0202;
        @(negedge clk);
        clear = 1'b0; tx_full = 1'b1; rx_empty = 1'b1;
        chk("clr_tx_data", {16'h0, tx_data}, 32'h0000);
        chk("clr_word_count", {8'h0, word_count}, 0);
        chk("clr_hunt", {31'h0, locked}, 0);
        feed(16'h0505);
        chk("clr_reseed_wc", {8'h0, word_count}, 0);
        feed(16'h0606);
        chk("clr_next_wc", {8'h0, word_count}, 1);
        chk("clr_next_err", {8'h0, err_count}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stream_pattern_tester.md
Name: stream_pattern_tester

Overview:
- Parametrised successor to the fixed 16-bit counter feeder/reader pair used to exercise the FT600 245-mode FIFO bridge.
- Generator half writes a selectable pattern (per-lane counter or LFSR) into the bridge TX FIFO; checker half drains the RX FIFO, locks onto the stream, and counts errors per lane.
- Tracks consecutive-error resync and captures the first error; drives an 8-bit LED status.
- Sits between the bridge FIFO ports and board LEDs in the loopback/throughput test top.

Parameters:
- DATA_WIDTH, 16, word width; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8, width of one counter lane; LANES = DATA_WIDTH/LANE_WIDTH.
- LFSR_TAPS, 16'hB400, Galois right-shift tap mask (DATA_WIDTH bits).
- LFSR_SEED, 1, non-zero LFSR reset/clear seed.
- COUNT_WIDTH, 24, width of word/error counters.
- RESYNC_THRESH, 4, consecutive mismatched words forcing relock.

Ports:
- clk  in  1  system clock; FIFO user side, all logic.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  enable; registered internally as run_q.
- clear  in  1  synchronous clear: counters, capture, pattern state.
- mode  in  1  0 = lane counter, 1 = LFSR; sampled only while run_q=0.
- tx_en  out  1  FIFO write strobe.
- tx_data  out  DATA_WIDTH  write data.
- tx_full  in  1  TX FIFO full.
- rx_en  out  1  FIFO read strobe; FIFO is first-word-fall-through.
- rx_data  in  DATA_WIDTH  read data; valid whenever rx_empty=0.
- rx_empty  in  1  RX FIFO empty.
- locked  out  1  checker in LOCKED state.
- word_count  out  COUNT_WIDTH  words checked while LOCKED.
- err_count  out  COUNT_WIDTH  mismatched lanes.
- resync_count  out  8  LOCKED->HUNT transitions.
- first_err_valid  out  1  capture registers hold data.
- first_err_exp  out  DATA_WIDTH  expected word at first error.
- first_err_got  out  DATA_WIDTH  received word at first error.
- status  out  8  word_count[8:1], for LEDs.

Behaviour:
- Reset (async, rst_n=0): run_q=0, mode_q=0, generator state=0 (counter) / LFSR_SEED (LFSR), checker HUNT, all counters 0, first_err_* 0. tx_en and rx_en are therefore 0.
- tx_en = run_q & ~tx_full (combinational; zero latency; never writes into a full FIFO).
- tx_data = current generator register. Generator steps on each clk edge with tx_en=1.
- rx_en = run_q & ~rx_empty. A word is consumed on each clk edge with rx_en=1.
- Pattern step, counter mode: every lane holds value v; next v = v+1 mod 2^LANE_WIDTH (16-bit: 0000, 0101, ... FFFF, 0000).
- Pattern step, LFSR mode: lsb = s[0]; s = s>>1; if lsb, s ^= LFSR_TAPS.
- mode_q loads from mode on each edge with run_q=0. A mode change reseeds the generator (0 or LFSR_SEED) and forces checker HUNT.
- Checker FSM, HUNT:
  - On a consumed word: expected <= step(received). In counter mode the seed is lane 0 of the received word. Go to LOCKED.
  - No counting on the seeding word.
- Checker FSM, LOCKED:
  - Each consumed word: word_count+1; compare per lane against expected; err_count += number of mismatching lanes.
  - expected <= step(expected), never re-derived from received.
  - Mismatching word: consec+1; on first error, capture exp/got and set first_err_valid.
  - Matching word: consec=0.
  - When consec reaches RESYNC_THRESH: go to HUNT, resync_count+1, consec=0.
- Counters (word_count, err_count, resync_count) saturate at all-ones and never wrap.
- clear=1: same effect as reset except run_q and mode_q. Clear beats generator step and checker consume in the same cycle; the word is still read or written on the bus but is not counted, and the pattern is reseeded.
- run falling: strobes stop the next cycle; all state is held.
- Async reset mid-transfer: strobes drop immediately; the partially driven word is lost by design.

Decomposition:
- pattern_pkg: mode encodings MODE_COUNT=0 and MODE_LFSR=1; FSM states ST_HUNT and ST_LOCKED; default tap constant.
- Sub-module pattern_step: combinational next-word function, parametrised like the top. Instanced twice: generator and checker expected.

Test Plan:
- Reset, run=1, mode=0, tx_full=0 for 258 cycles -> tx_data 0000, 0101, 0202, ..., FFFF, 0000, 0101; tx_en=1 every cycle.
- mode=1, run=1 -> tx_data 0001, B400, 5A00, 2D00, ...; err_count=0 in loopback.
- Loopback through a 16-deep model FIFO with random tx_full/rx_empty stalls, mode 0, 1000 words -> locked=1 after the first word; word_count=999; err_count=0; no write while full, no read while empty.
- Inject 0512 where 0505 is expected -> err_count=1; first_err_exp=0505, first_err_got=0512; the following 0606 is clean; locked stays 1.
- Drop one word from the stream in mode 0 -> every following word mismatches 2 lanes. After 4 words: err_count=8, resync_count=1, HUNT; the next word relocks; err_count then stays 8.
- Pull rst_n low mid-burst, then clear=1 with run=1 -> strobes and counters go to 0 immediately on reset. Clear reseeds the generator to 0000, and the word consumed during clear is not counted.
